timer_cmd_sender: RTL
=====================

Name: timer_cmd_sender

Overview:
- Host-side transmitter for the pattern-triggered programmable timer's serial command protocol.
- Takes a parallel delay command and serialises it onto the timer's `data` line: guard zeros, then start pattern 1101, then delay bits MSB-first.
- Then waits for the timer's `done` and returns a one-cycle `ack`, closing the handshake.
- Sits between the command source (CPU/register block) and the timer's data/done/ack pins.

Parameters:
- DELAY_W, 4, width of the delay field shifted after the pattern.
- PAT_W, 4, start-pattern length.
- PATTERN, 4'b1101, start pattern, sent MSB first.
- GAP_BITS, 2, zero bits driven before the pattern so the receiver detector is idle; 0 is legal.
- TIMEOUT, 20000, max cycles in WAIT_DONE before abort; must be ≥1.

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_delay  in  DELAY_W  delay value, sampled at acceptance
- data  out  1  serial line to timer, registered
- done  in  1  timer done (level, held until ack)
- ack  out  1  one-cycle acknowledge to timer, registered
- busy  out  1  state != IDLE
- timeout  out  1  one-cycle pulse when WAIT_DONE expires

Behaviour:
- Reset (synchronous, active-high, any state, including mid-stream):
  - next state IDLE; bit and timeout counters cleared.
  - data=0, ack=0, timeout=0, busy=0, cmd_ready=1.
- States: IDLE, GAP, PAT, DLY, WAIT_DONE, ACK.
- IDLE:
  - data=0. On acceptance, latch cmd_delay into the shift register.
  - Next state is GAP if GAP_BITS>0, else PAT. cmd_valid outside IDLE is ignored (not queued).
- GAP: data=0 for exactly GAP_BITS cycles, then PAT.
- PAT:
  - data = PATTERN[PAT_W-1-i] for i=0..PAT_W-1, one bit per cycle, then DLY.
  - No idle cycle between last pattern bit and first delay bit.
- DLY: data = latched delay bit DELAY_W-1 down to 0, one per cycle, then WAIT_DONE.
- WAIT_DONE:
  - data=0; timeout counter increments from 0.
  - done=1 goes to ACK, with the counter cleared.
  - If the counter reaches TIMEOUT-1 with done=0: timeout=1 for one cycle, go to IDLE, no ack.
  - done and expiry in the same cycle: done wins.
- ACK: ack=1 for exactly one cycle, data=0, then IDLE.
- Latency: acceptance at edge T means the first serial bit appears on data in cycle T+1. The last delay bit is in cycle T+GAP_BITS+PAT_W+DELAY_W.
- Command back-to-back: after ACK, IDLE lasts at least one cycle before the next acceptance.
- done is ignored in every state except WAIT_DONE (stale or glitch done never produces ack).
- Counters are sized as clog2 of their maximum, minimum width 1. There is no wrap: counters stop at the state transition.

Decomposition:
- Shared package timer_pkg holds:
  - the sender state enum;
  - PATTERN/PAT_W and DELAY_W defaults (so the receiver and sender agree).
- One sub-module, tx_shift_reg: parallel-load, MSB-first, left-shift register with load/shift enables. It is used for both the pattern (loaded with PATTERN) and the delay (loaded with the latched delay). Bit counting lives in the FSM.

Test Plan:
- Reset held 3 cycles, then released with cmd_valid=0 → data=0, ack=0, busy=0, cmd_ready=1 throughout.
- cmd_delay=4'b0101, defaults:
  - data sequence from T+1 is 0,0,1,1,0,1,0,1,0,1;
  - busy=1 and cmd_ready=0 from T+1;
  - drive done=1 five cycles after the last bit → ack=1 exactly one cycle later, then IDLE.
- Loopback with the real timer receiver, cmd_delay=4'b0000 and 4'b1111 → receiver counting lasts the delay-encoded duration, and its done clears one cycle after ack.
- done held high during GAP/PAT/DLY → no ack until WAIT_DONE; ack follows in the first ACK cycle.
- TIMEOUT=8, done never asserted → timeout pulses for one cycle 8 cycles into WAIT_DONE, ack stays 0, cmd_ready returns to 1.
- Reset asserted on the 2nd pattern bit → data=0 from the next cycle and state IDLE. A new command of 4'b1001 then sends the full 0,0,1,1,0,1,1,0,0,1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable-timer command protocol.
// Holds the sender FSM state encoding and the pattern/delay defaults that
// the sender and the timer's receiver must agree on.
package timer_pkg;

  localparam int                     TMR_PAT_W   = 4;
  localparam logic [TMR_PAT_W-1:0]   TMR_PATTERN = 4'b1101;
  localparam int                     TMR_DELAY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_PAT,
    ST_DLY,
    ST_WAIT_DONE,
    ST_ACK
  } tx_state_e;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/timer_cmd_sender_tx_shift_reg.sv
// Parallel-load, MSB-first, left-shifting register.
// Exposes the MSB it will hold after the coming edge so the caller can
// register a serial output aligned with the register contents.
module tx_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] load_val_i,
  output logic         msb_next_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // Load has priority over shift; zeros enter from the LSB end.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_val_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  assign msb_next_o = sr_d[W-1];

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/timer_cmd_sender.sv
// Host-side serialiser for the timer command protocol: guard zeros, start
// pattern, delay bits MSB-first, then waits for done and answers with ack.
// data/ack/timeout are registered; the bit shown on data always matches state_q.
module timer_cmd_sender
  import timer_pkg::*;
#(
  parameter int                 DELAY_W  = TMR_DELAY_W,
  parameter int                 PAT_W    = TMR_PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN  = TMR_PATTERN,
  parameter int                 GAP_BITS = 2,
  parameter int                 TIMEOUT  = 20000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DELAY_W-1:0] cmd_delay,
  output logic               data,
  input  logic               done,
  output logic               ack,
  output logic               busy,
  output logic               timeout
);

  localparam int SR_W  = (PAT_W > DELAY_W) ? PAT_W : DELAY_W;
  localparam int CNT_W = clog2_min1(max3(GAP_BITS, PAT_W, DELAY_W));
  localparam int TMO_W = clog2_min1(TIMEOUT);

  // Both fields are left-aligned so the shifter's MSB is always the next bit.
  localparam logic [SR_W-1:0] PAT_ALIGNED = SR_W'(PATTERN) << (SR_W - PAT_W);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);
  localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DELAY_W-1:0] dly_q;
  logic               data_q, data_d;
  logic               ack_q, ack_d;
  logic               timeout_q, timeout_d;

  logic               accept;
  logic               sr_load, sr_shift, sr_msb_next;
  logic [SR_W-1:0]    sr_load_val;

  assign accept = (state_q == ST_IDLE) && cmd_valid;

  tx_shift_reg #(.W(SR_W)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .load_val_i (sr_load_val),
    .msb_next_o (sr_msb_next)
  );

  // State, counters, latched delay and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      dly_q     <= '0;
      data_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      if (accept) begin
        dly_q <= cmd_delay;
      end
      data_q    <= data_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state: bit counter runs per serial phase, timeout counter only in WAIT_DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = (GAP_BITS > 0) ? ST_GAP : ST_PAT;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_PAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PAT: begin
        if (cnt_q == PAT_LAST) begin
          state_d = ST_DLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DLY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        // done wins over a same-cycle expiry.
        if (done) begin
          state_d = ST_ACK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: registered values are derived from the state being entered.
  always_comb begin
    sr_load     = (state_d == ST_PAT && state_q != ST_PAT) ||
                  (state_d == ST_DLY && state_q != ST_DLY);
    sr_shift    = (state_d == ST_PAT && state_q == ST_PAT) ||
                  (state_d == ST_DLY && state_q == ST_DLY);
    sr_load_val = (state_d == ST_PAT) ? PAT_ALIGNED
                                      : (SR_W'(dly_q) << (SR_W - DELAY_W));
    data_d      = (state_d == ST_PAT || state_d == ST_DLY) ? sr_msb_next : 1'b0;
    ack_d       = (state_d == ST_ACK);
    timeout_d   = (state_q == ST_WAIT_DONE) && (state_d == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    cmd_ready   = (state_q == ST_IDLE);
  end

  assign data    = data_q;
  assign ack     = ack_q;
  assign timeout = timeout_q;

endmodule
